// File: rtl/param_syncfifo.sv
// Parameterised synchronous FIFO with registered count/flags and one-cycle error pulses.
// Defining SYNCFIFO_FWFT_EN selects first-word-fall-through output; otherwise out is registered on each pop.
module param_syncfifo #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEPTH           = 16,
    parameter int ALMOST_FULL_TH  = DEPTH - 2,
    parameter int ALMOST_EMPTY_TH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write_en,
    input  logic                     read_en,
    input  logic [DATA_WIDTH-1:0]    data_in,
    output logic [DATA_WIDTH-1:0]    out,
    output logic                     mem_full,
    output logic                     mem_empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     wr_err,
    output logic                     rd_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_TH_C = CW'(ALMOST_FULL_TH);
    localparam logic [CW-1:0] AE_TH_C = CW'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          afull_q, afull_d;
    logic          aempty_q, aempty_d;
    logic          wr_err_q, wr_err_d;
    logic          rd_err_q, rd_err_d;
    logic          rd_acc, wr_acc;

    // A write into a full FIFO is still legal when the head is popped in the same cycle.
    always_comb begin
        rd_acc = read_en && !empty_q;
        wr_acc = write_en && (!full_q || rd_acc);
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Flags are derived from the next count so they land together with it.
    always_comb begin
        full_d   = (count_d == DEPTH_C);
        empty_d  = (count_d == '0);
        afull_d  = (count_d >= AF_TH_C);
        aempty_d = (count_d <= AE_TH_C);
        wr_err_d = write_en && !wr_acc;
        rd_err_d = read_en && !rd_acc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            afull_q  <= afull_d;
            aempty_q <= aempty_d;
            wr_err_q <= wr_err_d;
            rd_err_q <= rd_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYNCFIFO_FWFT_EN
    // Head word is visible as soon as it is stored; zero while empty so reset shows out=0.
    assign out = empty_q ? '0 : mem_q[rd_ptr_q];
`else
    logic [DATA_WIDTH-1:0] out_q, out_d;

    always_comb begin
        out_d = out_q;
        if (rd_acc) begin
            out_d = mem_q[rd_ptr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
`endif

    assign mem_full     = full_q;
    assign mem_empty    = empty_q;
    assign almost_full  = afull_q;
    assign almost_empty = aempty_q;
    assign count        = count_q;
    assign wr_err       = wr_err_q;
    assign rd_err       = rd_err_q;

endmodule
